// File: rtl/spi_flash_arbiter.sv
// Two-master SPI flash arbiter: request/grant ownership with a chip-select guard interval.
// Define SPI_FLASH_ARBITER_RR_EN for round-robin priority; default is fixed priority to master 0.
module spi_flash_arbiter #(
  parameter int GUARD_CYCLES = 4
) (
  input  logic clk_48mhz,
  input  logic reset_n,
  input  logic m0_req,
  output logic m0_gnt,
  input  logic m0_csel,
  input  logic m0_clk,
  input  logic m0_mosi,
  output logic m0_miso,
  input  logic m1_req,
  output logic m1_gnt,
  input  logic m1_csel,
  input  logic m1_clk,
  input  logic m1_mosi,
  output logic m1_miso,
  output logic spi_csel,
  output logic spi_clk,
  output logic spi_mosi,
  input  logic spi_miso,
  output logic busy,
  output logic err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    GUARD  = 2'd3
  } state_t;

  localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_guard_cnt;
  logic [7:0] w_next_guard_cnt;
  logic       r_err;
  logic       w_violation;
  logic       w_pick_m1;

`ifdef SPI_FLASH_ARBITER_RR_EN
  logic r_last_gnt;

  // On a tie the master that did not win last time gets the bus.
  always_comb begin
    w_pick_m1 = m1_req && (!m0_req || !r_last_gnt);
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_last_gnt <= 1'b1;
    end else if (r_state == IDLE && (w_next_state == GRANT0 || w_next_state == GRANT1)) begin
      r_last_gnt <= (w_next_state == GRANT1);
    end
  end
`else
  always_comb begin
    w_pick_m1 = m1_req && !m0_req;
  end
`endif

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_guard_cnt <= 8'd0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_guard_cnt <= w_next_guard_cnt;
      if (w_violation) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_next_guard_cnt = r_guard_cnt;
    case (r_state)
      IDLE: begin
        if (m0_req || m1_req) begin
          w_next_state = w_pick_m1 ? GRANT1 : GRANT0;
        end
      end
      GRANT0: begin
        if (!m0_req) begin
          w_next_state     = GUARD;
          w_next_guard_cnt = GUARD_LOAD;
        end
      end
      GRANT1: begin
        if (!m1_req) begin
          w_next_state     = GUARD;
          w_next_guard_cnt = GUARD_LOAD;
        end
      end
      GUARD: begin
        if (r_guard_cnt == 8'd0) begin
          w_next_state = IDLE;
        end else begin
          w_next_guard_cnt = r_guard_cnt - 8'd1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Chip select low without ownership, or dropping req while still selected.
  always_comb begin
    w_violation = 1'b0;
    if (!m0_csel && r_state != GRANT0) begin
      w_violation = 1'b1;
    end
    if (!m1_csel && r_state != GRANT1) begin
      w_violation = 1'b1;
    end
    if (r_state == GRANT0 && !m0_req && !m0_csel) begin
      w_violation = 1'b1;
    end
    if (r_state == GRANT1 && !m1_req && !m1_csel) begin
      w_violation = 1'b1;
    end
  end

  always_comb begin
    spi_csel = 1'b1;
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    m0_miso  = 1'b0;
    m1_miso  = 1'b0;
    case (r_state)
      GRANT0: begin
        spi_csel = m0_csel;
        spi_clk  = m0_clk;
        spi_mosi = m0_mosi;
        m0_miso  = spi_miso;
      end
      GRANT1: begin
        spi_csel = m1_csel;
        spi_clk  = m1_clk;
        spi_mosi = m1_mosi;
        m1_miso  = spi_miso;
      end
      default: begin
        spi_csel = 1'b1;
      end
    endcase
  end

  assign m0_gnt = (r_state == GRANT0);
  assign m1_gnt = (r_state == GRANT1);
  assign busy   = (r_state != IDLE);
  assign err    = r_err;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed self-checking bench for spi_flash_arbiter (GUARD_CYCLES = 4).
// Honours SPI_FLASH_ARBITER_RR_EN for the expected tie-break order.
module tb_spi_flash_arbiter;

  logic clk_48mhz = 1'b0;
  logic reset_n   = 1'b0;
  logic m0_req = 1'b0, m0_csel = 1'b1, m0_clk = 1'b0, m0_mosi = 1'b0;
  logic m1_req = 1'b0, m1_csel = 1'b1, m1_clk = 1'b0, m1_mosi = 1'b0;
  logic spi_miso = 1'b0;
  logic m0_gnt, m0_miso, m1_gnt, m1_miso;
  logic spi_csel, spi_clk, spi_mosi, busy, err;
  logic [8:0] obs;
  int checks = 0;
  int passed = 0;

  spi_flash_arbiter #(.GUARD_CYCLES(4)) dut (
    .clk_48mhz(clk_48mhz), .reset_n(reset_n),
    .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_csel(m0_csel), .m0_clk(m0_clk),
    .m0_mosi(m0_mosi), .m0_miso(m0_miso),
    .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_csel(m1_csel), .m1_clk(m1_clk),
    .m1_mosi(m1_mosi), .m1_miso(m1_miso),
    .spi_csel(spi_csel), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .busy(busy), .err(err)
  );

  always #10 clk_48mhz = ~clk_48mhz;

  assign obs = {m0_gnt, m1_gnt, spi_csel, spi_clk, spi_mosi, m0_miso, m1_miso, busy, err};

  // Both grants must never be high together.
  always @(negedge clk_48mhz) begin
    checks++;
    if ((m0_gnt && m1_gnt) !== 1'b0)
      $display("[TB] FAIL dual_grant: m0_gnt=%b m1_gnt=%b, required not both 1", m0_gnt, m1_gnt);
    else
      passed++;
  end

  task automatic tick();
    @(posedge clk_48mhz);
    #1;
  endtask

  task automatic do_reset();
    m0_req = 0; m0_csel = 1; m0_clk = 0; m0_mosi = 0;
    m1_req = 0; m1_csel = 1; m1_clk = 0; m1_mosi = 0;
    spi_miso = 0;
    reset_n = 0;
    tick();
    reset_n = 1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 0;
    tick();
    tick();
    checks++;
    if (obs !== 9'b001000000)
      $display("[TB] FAIL reset_state: got %b, required %b", obs, 9'b001000000);
    else passed++;
    reset_n = 1;
    tick();
    checks++;
    if (obs !== 9'b001000000)
      $display("[TB] FAIL idle_after_reset: got %b, required %b", obs, 9'b001000000);
    else passed++;
  endtask

  task automatic test_grant_m0();
    m0_req = 1;
    #1;
    checks++;
    if (m0_gnt !== 1'b0)
      $display("[TB] FAIL gnt0_early: got %b, required 0", m0_gnt);
    else passed++;
    tick();
    checks++;
    if (m0_gnt !== 1'b1)
      $display("[TB] FAIL gnt0_latency: got %b, required 1", m0_gnt);
    else passed++;
    m0_csel = 0; m0_clk = 1; m0_mosi = 1; spi_miso = 1;
    #1;
    checks++;
    if (obs !== 9'b100111010)
      $display("[TB] FAIL mux_m0_a: got %b, required %b", obs, 9'b100111010);
    else passed++;
    m0_clk = 0; spi_miso = 0;
    #1;
    checks++;
    if (obs !== 9'b100010010)
      $display("[TB] FAIL mux_m0_b: got %b, required %b", obs, 9'b100010010);
    else passed++;
    m0_csel = 1; m0_mosi = 0; spi_miso = 1;
    #1;
    checks++;
    if (obs !== 9'b101001010)
      $display("[TB] FAIL mux_m0_c: got %b, required %b", obs, 9'b101001010);
    else passed++;
    spi_miso = 0;
    tick();
  endtask

  task automatic test_guard_handover();
    m0_req = 0;
    m1_req = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs !== 9'b001000010)
        $display("[TB] FAIL guard_cycle%0d: got %b, required %b", i, obs, 9'b001000010);
      else passed++;
    end
    tick();
    checks++;
    if (obs !== 9'b001000000)
      $display("[TB] FAIL guard_idle: got %b, required %b", obs, 9'b001000000);
    else passed++;
    tick();
    checks++;
    if (obs !== 9'b011000010)
      $display("[TB] FAIL gnt1_after_guard: got %b, required %b", obs, 9'b011000010);
    else passed++;
    m1_csel = 0; m1_clk = 1; spi_miso = 1;
    #1;
    checks++;
    if (obs !== 9'b010100110)
      $display("[TB] FAIL mux_m1: got %b, required %b", obs, 9'b010100110);
    else passed++;
    m1_csel = 1; m1_clk = 0; spi_miso = 0;
    tick();
    m1_req = 0;
    repeat (5) tick();
    checks++;
    if (obs !== 9'b001000000)
      $display("[TB] FAIL m1_release_idle: got %b, required %b", obs, 9'b001000000);
    else passed++;
  endtask

  task automatic test_priority();
    logic [1:0] exp_gnt [4];
`ifdef SPI_FLASH_ARBITER_RR_EN
    exp_gnt = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
    exp_gnt = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
    do_reset();
    for (int r = 0; r < 4; r++) begin
      m0_req = 1;
      m1_req = 1;
      tick();
      checks++;
      if ({m0_gnt, m1_gnt} !== exp_gnt[r])
        $display("[TB] FAIL tie_round%0d: got gnt=%b, required %b", r, {m0_gnt, m1_gnt}, exp_gnt[r]);
      else passed++;
      m0_req = 0;
      m1_req = 0;
      repeat (5) tick();
      checks++;
      if (busy !== 1'b0)
        $display("[TB] FAIL tie_idle%0d: got busy=%b, required 0", r, busy);
      else passed++;
    end
  endtask

  task automatic test_violation();
    m0_req = 1;
    tick();
    m0_csel = 0; m0_clk = 1; m0_mosi = 0;
    m1_csel = 0; m1_clk = 1; m1_mosi = 1; spi_miso = 1;
    #1;
    checks++;
    if (obs !== 9'b100101010)
      $display("[TB] FAIL intruder_mux: got %b, required %b", obs, 9'b100101010);
    else passed++;
    tick();
    checks++;
    if (obs !== 9'b100101011)
      $display("[TB] FAIL intruder_err: got %b, required %b", obs, 9'b100101011);
    else passed++;
    m1_csel = 1; m0_csel = 1;
    tick();
    checks++;
    if (obs !== 9'b101101011)
      $display("[TB] FAIL err_sticky: got %b, required %b", obs, 9'b101101011);
    else passed++;
    m0_clk = 0; m1_clk = 0; m1_mosi = 0; spi_miso = 0;
    m0_req = 0;
    repeat (5) tick();
  endtask

  task automatic test_release_violation();
    do_reset();
    m0_req = 1;
    tick();
    m0_csel = 0;
    tick();
    checks++;
    if ({spi_csel, err} !== 2'b00)
      $display("[TB] FAIL legal_select: got csel,err=%b, required 00", {spi_csel, err});
    else passed++;
    m0_req = 0;
    #1;
    checks++;
    if ({m0_gnt, spi_csel} !== 2'b10)
      $display("[TB] FAIL pre_release: got gnt,csel=%b, required 10", {m0_gnt, spi_csel});
    else passed++;
    tick();
    checks++;
    if ({m0_gnt, spi_csel, busy, err} !== 4'b0111)
      $display("[TB] FAIL forced_release: got gnt,csel,busy,err=%b, required 0111",
               {m0_gnt, spi_csel, busy, err});
    else passed++;
    m0_csel = 1;
    repeat (5) tick();
    checks++;
    if ({busy, err} !== 2'b01)
      $display("[TB] FAIL release_sticky: got busy,err=%b, required 01", {busy, err});
    else passed++;
  endtask

  task automatic test_reset_mid_transfer();
    do_reset();
    m0_req = 1;
    tick();
    m0_csel = 0; m0_clk = 1;
    #1;
    checks++;
    if ({spi_csel, spi_clk} !== 2'b01)
      $display("[TB] FAIL mid_active: got csel,clk=%b, required 01", {spi_csel, spi_clk});
    else passed++;
    #2;
    reset_n = 0;
    #1;
    checks++;
    if ({m0_gnt, spi_csel, spi_clk, busy} !== 4'b0100)
      $display("[TB] FAIL async_reset: got gnt,csel,clk,busy=%b, required 0100",
               {m0_gnt, spi_csel, spi_clk, busy});
    else passed++;
    m0_req = 0; m0_csel = 1; m0_clk = 0;
    tick();
    reset_n = 1;
    tick();
    tick();
    checks++;
    if ({m0_gnt, m1_gnt, busy, err} !== 4'b0000)
      $display("[TB] FAIL post_reset_idle: got gnt0,gnt1,busy,err=%b, required 0000",
               {m0_gnt, m1_gnt, busy, err});
    else passed++;
    m0_req = 1;
    #1;
    checks++;
    if (m0_gnt !== 1'b0)
      $display("[TB] FAIL fresh_req_early: got %b, required 0", m0_gnt);
    else passed++;
    tick();
    checks++;
    if (m0_gnt !== 1'b1)
      $display("[TB] FAIL fresh_req_grant: got %b, required 1", m0_gnt);
    else passed++;
    m0_req = 0;
    repeat (5) tick();
  endtask

  initial begin
    $display("[TB] spi_flash_arbiter bench start");
    test_reset();
    test_grant_m0();
    test_guard_handover();
    test_priority();
    test_violation();
    test_release_violation();
    test_reset_mid_transfer();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/spi_flash_arbiter.md
Name: spi_flash_arbiter

Overview:
- Shares the single SPI flash port (spi_csel/spi_clk/spi_mosi/spi_miso) between two SPI masters.
  - Master 0: the DFU core's flash engine.
  - Master 1: a secondary requester, e.g. the boot-image/config reader.
- Sits between the masters and the flash pins, next to the USB DFU wrapper.
- Uses a request/grant handshake and only switches owner when the flash is deselected.
- Enforces a guard interval with chip select high between bus owners.

Parameters:
- GUARD_CYCLES, 4: clk_48mhz cycles that spi_csel is forced high after a release. Legal range is 1..255.

Ports:
- clk_48mhz  in  1  system clock, 48 MHz
- reset_n  in  1  asynchronous active-low reset
- m0_req  in  1  master 0 requests the flash
- m0_gnt  out  1  master 0 owns the flash
- m0_csel  in  1  master 0 chip select, active low
- m0_clk  in  1  master 0 SPI clock, mode 0 (idles low)
- m0_mosi  in  1  master 0 data out
- m0_miso  out  1  flash data to master 0
- m1_req, m1_gnt, m1_csel, m1_clk, m1_mosi, m1_miso: same as the m0_* ports, for master 1
- spi_csel  out  1  flash chip select, active low
- spi_clk  out  1  flash clock
- spi_mosi  out  1  flash data in
- spi_miso  in  1  flash data out
- busy  out  1  any grant active or guard running
- err  out  1  sticky; set on a protocol violation

Behaviour:
- Reset: one clock, clk_48mhz; reset is asynchronous and active-low (reset_n).
  - Reset state is IDLE, m0_gnt=m1_gnt=0, spi_csel=1, spi_clk=0, spi_mosi=0, m0_miso=m1_miso=0, busy=0, err=0.
  - The guard counter clears to 0. The last-grant register clears to 1, so master 0 is preferred first.
  - Reset asserted mid-transfer deselects the flash immediately (asynchronously). No owner exists after release.
- State register: IDLE, GRANT0, GRANT1, GUARD. All states are registered.
- SPI output muxing:
  - The SPI outputs are combinational muxes selected by the registered state. They add zero latency.
  - GRANTx: spi_csel=mx_csel, spi_clk=mx_clk, spi_mosi=mx_mosi, mx_miso=spi_miso, and the other master's miso=0.
  - IDLE and GUARD: spi_csel=1, spi_clk=0, spi_mosi=0, both miso=0.
- IDLE:
  - If exactly one req is high, move to that master's GRANT state on the next edge. Its gnt rises on that edge, one cycle after req is sampled.
  - If both req are high, the priority rule picks the winner; the loser keeps waiting.
  - If neither req is high, stay in IDLE.
- GRANTx:
  - gnt stays high while mx_req=1.
  - When mx_req is sampled 0, move to GUARD: gnt falls and the counter loads GUARD_CYCLES-1.
  - The release takes effect even if mx_csel is still low. In that case set err and force the deselect.
- GUARD:
  - The counter decrements each cycle; at 0, move to IDLE. spi_csel is therefore high for exactly GUARD_CYCLES cycles.
  - Requests arriving during GUARD are held by the requester and evaluated in IDLE. There is no IDLE-skip.
- Handshake rules for masters:
  - Assert req and hold it.
  - Drive csel low only while gnt=1.
  - Return csel high before dropping req.
  - Drop req for at least one cycle between transactions.
- Violations: set err (sticky until reset) if a non-granted master drives its csel low, in any state. Its signals are never forwarded.
- busy = (state != IDLE).
- A req held high with no gnt waits indefinitely. There is no timeout.

Optional Feature:
- Macro: SPI_FLASH_ARBITER_RR_EN.
- When defined: round-robin priority. On a simultaneous request in IDLE, the master not in the last-grant register wins. The last-grant register updates on every grant.
- When undefined: fixed priority. Master 0 always wins a simultaneous request, and no last-grant register is built.

Test Plan:
- After reset_n release, m0_req=1 -> m0_gnt=1 exactly 1 cycle later. Toggle m0_csel/m0_clk/m0_mosi -> spi_* match in the same cycle, and m0_miso follows spi_miso.
- m0 releases with GUARD_CYCLES=4 while m1_req is pending -> spi_csel high for exactly 4 cycles in GUARD, then 1 IDLE cycle, then m1_gnt=1. m0_gnt and m1_gnt are never both 1.
- Both req rise in the same cycle, repeated 4 times:
  - Without SPI_FLASH_ARBITER_RR_EN -> grant order 0,0,0,0.
  - With SPI_FLASH_ARBITER_RR_EN -> grant order 0,1,0,1.
- m1_csel=0 while m0 is granted -> err=1 and stays 1, spi_csel still follows m0_csel, m1_miso=0.
- m0 drops req while m0_csel=0 -> spi_csel=1 on the next cycle and err=1.
- reset_n pulsed low mid-transfer (spi_csel=0, spi_clk toggling) -> spi_csel=1 and spi_clk=0 with no clock edge. After release: state IDLE, no gnt until a fresh req.
